// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: RV32 execute stage with forwarding, ALU, branch unit, optional iterative M-extension unit and the E->M register
//
// Optional feature macro: MDU_EN (define to build the multiply/divide unit; undefined ties BusyE low)
//
// Ports:
//   clk, rst (async, active-low)
//   RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, BranchCondE, ALUControlE   decoded controls
//   MulDivE, MulDivOpE                                                             M-extension controls
//   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E                                   operands, PCs, destination
//   ResultW, ForwardA_E, ForwardB_E                                                forwarding
//   PCSrcE, PCTargetE, BusyE                                                       combinational outputs
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM       E->M register
module execute_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              ALUSrcE,
    input  logic              BranchE,
    input  logic [2:0]        BranchCondE,
    input  logic [3:0]        ALUControlE,
    input  logic              MulDivE,
    input  logic [2:0]        MulDivOpE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              BusyE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   ALU_ResultM
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_srca, w_rd2f, w_srcb, w_alu, w_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_eq, w_lt, w_ltu, w_cond;

    assign w_srca  = (ForwardA_E == 2'b01) ? ResultW : (ForwardA_E == 2'b10) ? ALU_ResultM : RD1_E;
    assign w_rd2f  = (ForwardB_E == 2'b01) ? ResultW : (ForwardB_E == 2'b10) ? ALU_ResultM : RD2_E;
    assign w_srcb  = ALUSrcE ? Imm_Ext_E : w_rd2f;
    assign w_shamt = w_srcb[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            4'b0000: w_alu = w_srca + w_srcb;
            4'b0001: w_alu = w_srca - w_srcb;
            4'b0010: w_alu = w_srca & w_srcb;
            4'b0011: w_alu = w_srca | w_srcb;
            4'b0100: w_alu = w_srca ^ w_srcb;
            4'b0101: w_alu = {{(XLEN-1){1'b0}}, $signed(w_srca) < $signed(w_srcb)};
            4'b0110: w_alu = {{(XLEN-1){1'b0}}, w_srca < w_srcb};
            4'b0111: w_alu = w_srca << w_shamt;
            4'b1000: w_alu = w_srca >> w_shamt;
            4'b1001: w_alu = $signed(w_srca) >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Branches compare the forwarded rs2 value, never the immediate
    assign w_eq  = (w_srca == w_rd2f);
    assign w_lt  = ($signed(w_srca) < $signed(w_rd2f));
    assign w_ltu = (w_srca < w_rd2f);

    always_comb begin
        w_cond = 1'b0;
        case (BranchCondE)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state, w_next;
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_a;
    logic [2*XLEN-1:0] r_p;
    logic [2:0]        r_op;
    logic              r_neg;

    logic              w_isdiv, w_sa, w_sb, w_neg, w_dz, w_ovf, w_special, w_start;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_q, w_r, w_fsm_res, w_mdu_res;
    logic [XLEN:0]     w_madd, w_rsh, w_diff;
    logic [2*XLEN-1:0] w_mstep, w_dstep, w_pn;

    assign w_isdiv = MulDivOpE[2];
    // Signed interpretation: rs1 for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
    assign w_sa    = (MulDivOpE == 3'b001 || MulDivOpE == 3'b010 || MulDivOpE == 3'b100 || MulDivOpE == 3'b110) & w_srca[XLEN-1];
    assign w_sb    = (MulDivOpE == 3'b001 || MulDivOpE == 3'b100 || MulDivOpE == 3'b110) & w_rd2f[XLEN-1];
    assign w_mag_a = w_sa ? -w_srca : w_srca;
    assign w_mag_b = w_sb ? -w_rd2f : w_rd2f;
    // Remainder takes the dividend's sign; products and quotients the xor of both
    assign w_neg   = (MulDivOpE == 3'b110) ? w_sa : (w_sa ^ w_sb);

    assign w_dz       = w_isdiv & (w_rd2f == '0);
    assign w_ovf      = w_isdiv & ~MulDivOpE[0] & (w_srca == MIN_NEG) & (w_rd2f == '1);
    assign w_special  = w_dz | w_ovf;
    assign w_spec_res = MulDivOpE[1] ? (w_dz ? w_srca : '0) : (w_dz ? '1 : w_srca);

    assign w_start = (r_state == S_IDLE) & MulDivE & ~w_special;
    assign BusyE   = w_start | (r_state == S_BUSY);

    // Multiply: r_p = {partial high, remaining multiplier}; add then shift right
    assign w_madd  = {1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, r_a & {XLEN{r_p[0]}}};
    assign w_mstep = {w_madd, r_p[XLEN-1:1]};
    // Divide: r_p = {partial remainder, dividend/quotient}; shift left then trial-subtract
    assign w_rsh   = r_p[2*XLEN-1:XLEN-1];
    assign w_diff  = w_rsh - {1'b0, r_a};
    assign w_dstep = w_diff[XLEN] ? {w_rsh[XLEN-1:0], r_p[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};

    assign w_pn      = r_neg ? -r_p : r_p;
    assign w_q       = r_neg ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
    assign w_r       = r_neg ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN];
    assign w_fsm_res = ~r_op[2] ? ((r_op[1:0] == 2'b00) ? w_pn[XLEN-1:0] : w_pn[2*XLEN-1:XLEN])
                                : (r_op[1] ? w_r : w_q);
    // Outside DONE only special cases reach the M register
    assign w_mdu_res = (r_state == S_DONE) ? w_fsm_res : w_spec_res;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_BUSY : S_IDLE;
            S_BUSY:  w_next = (r_cnt == SHW'(XLEN-1)) ? S_DONE : S_BUSY;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_p     <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt <= '0;
                r_op  <= MulDivOpE;
                r_neg <= w_neg;
                r_a   <= w_isdiv ? w_mag_b : w_mag_a;
                r_p   <= {{XLEN{1'b0}}, w_isdiv ? w_mag_a : w_mag_b};
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                r_p   <= r_op[2] ? w_dstep : w_mstep;
            end
        end
    end

    assign w_res  = MulDivE ? w_mdu_res : w_alu;
    assign PCSrcE = BranchE & w_cond & ~MulDivE;
`else
    logic w_unused;

    assign w_unused = ^{MulDivE, MulDivOpE};
    assign BusyE    = 1'b0;
    assign w_res    = w_alu;
    assign PCSrcE   = BranchE & w_cond;
`endif

    // A stall loads a bubble so the instruction ahead drains from M
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= BusyE ? 1'b0 : RegWriteE;
            MemWriteM   <= BusyE ? 1'b0 : MemWriteE;
            ResultSrcM  <= BusyE ? 1'b0 : ResultSrcE;
            RD_M        <= BusyE ? '0 : RD_E;
            PCPlus4M    <= BusyE ? '0 : PCPlus4E;
            WriteDataM  <= BusyE ? '0 : w_rd2f;
            ALU_ResultM <= BusyE ? '0 : w_res;
        end
    end
endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb_execute_stage_mdu: scoreboard bench for execute_stage_mdu
module tb_execute_stage_mdu;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0, rst = 1'b0;
    logic            RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, MulDivE;
    logic [2:0]      BranchCondE, MulDivOpE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [AW-1:0]   RD_E;
    logic [1:0]      ForwardA_E, ForwardB_E;
    logic            PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
    logic [XLEN-1:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [AW-1:0]   RD_M;

    execute_stage_mdu #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BranchCondE(BranchCondE),
        .ALUControlE(ALUControlE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [7:0]  ctl;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_res = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, wd, pc4, input logic [7:0] ctl);
        return {res, wd, pc4, ctl};
    endfunction

    function automatic logic [31:0] alu_m(input logic [3:0] c, input logic [31:0] a, b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Monitor pops one expectation per edge that has one queued
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("m_res", {32'd0, ALU_ResultM}, {32'd0, m_e.res});
            chk("m_wdata", {32'd0, WriteDataM}, {32'd0, m_e.wd});
            chk("m_pc4", {32'd0, PCPlus4M}, {32'd0, m_e.pc4});
            chk("m_ctl", {56'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M}, {56'd0, m_e.ctl});
        end
    end

    task automatic go(input exp_t e);
        q.push_back(e);
        m_res = e.res;
        @(negedge clk);
    endtask

    task automatic clr();
        {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, MulDivE} = '0;
        BranchCondE = '0; MulDivOpE = '0; ALUControlE = '0;
        RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; PCPlus4E = '0;
        RD_E = '0; ForwardA_E = '0; ForwardB_E = '0;
    endtask

    task automatic alu_dir(input logic [3:0] c, input logic [31:0] a, b, r);
        clr();
        ALUControlE = c; RD1_E = a; RD2_E = b; RegWriteE = 1'b1; RD_E = 5'd9; PCPlus4E = a ^ b;
        go(mk(r, b, a ^ b, {3'b100, 5'd9}));
    endtask

    task automatic br(input logic [2:0] cond, input logic [31:0] a, b, input logic en, input logic exp);
        clr();
        BranchE = en; BranchCondE = cond; RD1_E = a; RD2_E = b; ALUControlE = 4'd1;
        PCE = 32'h2000; Imm_Ext_E = 32'h40;
        #1;
        chk("pcsrc", {63'd0, PCSrcE}, {63'd0, exp});
        chk("pctgt", {32'd0, PCTargetE}, 64'h2040);
        go(mk(a - b, b, 32'd0, 8'd0));
    endtask

`ifdef MDU_EN
    localparam logic [31:0] MINV = 32'h8000_0000;

    function automatic logic [31:0] mdu_m(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, ua, ub, p;
        logic ovf;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin p = sa / sb; return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : p[31:0]; end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin p = sa % sb; return (b == 0) ? a : ovf ? 32'd0 : p[31:0]; end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic mdu_op(input logic [2:0] op, input logic [31:0] a, b, input bit stall);
        clr();
        MulDivE = 1'b1; MulDivOpE = op; RD1_E = a; RD2_E = b; RegWriteE = 1'b1; RD_E = 5'd11;
        if (stall)
            for (int i = 0; i <= XLEN; i++) begin
                #1;
                chk("busy", {63'd0, BusyE}, 64'd1);
                go(mk(32'd0, 32'd0, 32'd0, 8'd0));
                if (i == 0) RD1_E = ~a;
            end
        #1;
        chk("busy_end", {63'd0, BusyE}, 64'd0);
        go(mk(mdu_m(op, a, b), b, 32'd0, {3'b100, 5'd11}));
        clr();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] a, r2, b;
        clr();
        ResultW = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {56'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M}, 64'd0);
        chk("rst_res", {32'd0, ALU_ResultM}, 64'd0);
        chk("rst_wd", {32'd0, WriteDataM}, 64'd0);
        chk("rst_pc4", {32'd0, PCPlus4M}, 64'd0);
        chk("rst_busy", {63'd0, BusyE}, 64'd0);
        chk("rst_pcsrc", {63'd0, PCSrcE}, 64'd0);
        chk("rst_pctgt", {32'd0, PCTargetE}, 64'd0);
        rst = 1'b1;
        m_res = '0;

        // ALU_ResultM=100 then ADD forwarding it: 100 + 7
        clr(); RegWriteE = 1'b1; RD_E = 5'd3; RD1_E = 32'd60; RD2_E = 32'd40; PCPlus4E = 32'h104;
        go(mk(32'd100, 32'd40, 32'h104, {3'b100, 5'd3}));
        RD1_E = 32'd5; RD2_E = 32'd7; ForwardA_E = 2'b10;
        go(mk(32'd107, 32'd7, 32'h104, {3'b100, 5'd3}));

        alu_dir(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_dir(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu_dir(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
        alu_dir(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu_dir(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_dir(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_dir(4'd7, 32'd1, 32'h3F, 32'h8000_0000);
        alu_dir(4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_dir(4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_dir(4'd9, 32'h7FFF_FFFF, 32'h21, 32'h3FFF_FFFF);
        alu_dir(4'd10, 32'd5, 32'd7, 32'd0);
        alu_dir(4'd15, 32'd5, 32'd7, 32'd0);

        // Forwarding and store data paths
        clr(); ResultW = 32'h1000; ForwardA_E = 2'b01; RD1_E = 32'd9; RD2_E = 32'd2;
        go(mk(32'h1002, 32'd2, 32'd0, 8'd0));
        clr(); ForwardB_E = 2'b01; RD1_E = 32'd9; RD2_E = 32'd2;
        go(mk(32'h1009, 32'h1000, 32'd0, 8'd0));
        clr(); ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'd9; RD2_E = 32'd2;
        go(mk(32'd11, 32'd2, 32'd0, 8'd0));
        clr(); ALUSrcE = 1'b1; Imm_Ext_E = 32'h10; RD1_E = 32'd1; RD2_E = 32'h55;
        MemWriteE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd31;
        go(mk(32'h11, 32'h55, 32'd0, {3'b011, 5'd31}));
        clr(); ForwardB_E = 2'b10; RD1_E = 32'd1; RD2_E = 32'h77;
        go(mk(32'h12, 32'h11, 32'd0, 8'd0));

        // Branch conditions
        br(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        br(3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        br(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        br(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        br(3'b000, 32'd5, 32'd5, 1'b1, 1'b1);
        br(3'b001, 32'd5, 32'd5, 1'b1, 1'b0);
        br(3'b001, 32'd5, 32'd6, 1'b1, 1'b1);
        br(3'b010, 32'd5, 32'd5, 1'b1, 1'b0);
        br(3'b011, 32'd1, 32'd2, 1'b1, 1'b0);
        br(3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
        // Branch uses forwarded operands and ignores the immediate as SrcB
        clr(); BranchE = 1'b1; BranchCondE = 3'b000; ALUSrcE = 1'b1; Imm_Ext_E = 32'h40;
        ForwardA_E = 2'b01; ResultW = 32'd8; RD1_E = 32'd3; RD2_E = 32'd8;
        #1;
        chk("br_fwd", {63'd0, PCSrcE}, 64'd1);
        go(mk(32'h48, 32'd8, 32'd0, 8'd0));

        for (int i = 0; i < 30; i++) begin
            clr();
            c = 4'($urandom_range(0, 11));
            ALUControlE = c;
            ForwardA_E = 2'($urandom_range(0, 3));
            ForwardB_E = 2'($urandom_range(0, 3));
            ALUSrcE = 1'($urandom_range(0, 1));
            RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; ResultW = $urandom;
            RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1)); RD_E = 5'($urandom_range(0, 31));
            PCPlus4E = $urandom;
            a  = (ForwardA_E == 2'b01) ? ResultW : (ForwardA_E == 2'b10) ? m_res : RD1_E;
            r2 = (ForwardB_E == 2'b01) ? ResultW : (ForwardB_E == 2'b10) ? m_res : RD2_E;
            b  = ALUSrcE ? Imm_Ext_E : r2;
            go(mk(alu_m(c, a, b), r2, PCPlus4E, {RegWriteE, MemWriteE, ResultSrcE, RD_E}));
        end

`ifdef MDU_EN
        mdu_op(3'd1, 32'h8000_0000, 32'd2, 1'b1);
        mdu_op(3'd4, 32'd7, 32'd0, 1'b0);
        mdu_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        mdu_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        mdu_op(3'd7, 32'd7, 32'd0, 1'b0);
        mdu_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        mdu_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        mdu_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        mdu_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        mdu_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        mdu_op(3'd7, 32'd100, 32'd7, 1'b1);
        // DIVU interrupted by reset in BUSY cycle 10, then reissued
        clr(); MulDivE = 1'b1; MulDivOpE = 3'd5; RD1_E = 32'd100; RD2_E = 32'd7; RegWriteE = 1'b1; RD_E = 5'd11;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("busy_pre_rst", {63'd0, BusyE}, 64'd1);
            go(mk(32'd0, 32'd0, 32'd0, 8'd0));
        end
        clr();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, BusyE}, 64'd0);
        chk("mid_rst_m", {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, 24'd0}, 64'd0);
        chk("mid_rst_wd", {32'd0, WriteDataM | PCPlus4M}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m_res = '0;
        mdu_op(3'd5, 32'd100, 32'd7, 1'b1);
`else
        clr(); MulDivE = 1'b1; MulDivOpE = 3'd4; RD1_E = 32'd3; RD2_E = 32'd4; RegWriteE = 1'b1; RD_E = 5'd2;
        #1;
        chk("nomdu_busy", {63'd0, BusyE}, 64'd0);
        go(mk(32'd7, 32'd4, 32'd0, {3'b100, 5'd2}));
        clr(); MulDivE = 1'b1; MulDivOpE = 3'd0; ALUControlE = 4'd1; RD1_E = 32'd3; RD2_E = 32'd4;
        #1;
        chk("nomdu_busy2", {63'd0, BusyE}, 64'd0);
        go(mk(32'hFFFF_FFFF, 32'd4, 32'd0, 8'd0));
`endif

        chk("drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
